// File: rtl/calc_arbiter.sv
// Round-robin arbiter that shares one 4-bit add/sub/mul/div unit between NREQ requesters.
// Only one operation is in flight at a time; saturating counters track completed and errored operations.
module calc_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [7:0]        resp_result,
  output logic              resp_error,
  output logic [CNTW-1:0]   op_count,
  output logic [CNTW-1:0]   err_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cap_id;
  logic [3:0]     cap_a, cap_b;
  logic [1:0]     cap_op;

  logic           hi_found, lo_found, gnt_found;
  logic [IDW-1:0] hi_id, lo_id, gnt_id;
  logic [3:0]     gnt_a, gnt_b;
  logic [1:0]     gnt_op;
  logic [NREQ-1:0] gnt_vec;

  logic [7:0]     alu_result;
  logic           alu_error;

  // Round-robin: the lowest valid index above the pointer wins, otherwise the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (i > 32'(ptr)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_id    = i[IDW-1:0];
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = i[IDW-1:0];
        end
      end
    end
    gnt_found = hi_found | lo_found;
    gnt_id    = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_op  = '0;
    gnt_vec = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_id == i[IDW-1:0]) begin
        gnt_a      = req_a[4*i +: 4];
        gnt_b      = req_b[4*i +: 4];
        gnt_op     = req_op[2*i +: 2];
        gnt_vec[i] = (state == IDLE) && gnt_found;
      end
    end
  end

  assign req_ready = gnt_vec;
  assign busy      = (state != IDLE);

  always_comb begin
    alu_result = '0;
    alu_error  = 1'b0;
    unique case (cap_op)
      2'b00: alu_result = {4'b0, cap_a} + {4'b0, cap_b};
      2'b01: alu_result = {4'b0, cap_a} - {4'b0, cap_b};
      2'b10: alu_result = 8'(cap_a) * 8'(cap_b);
      2'b11: begin
        if (cap_b == 4'd0) begin
          alu_error = 1'b1;
        end else begin
          alu_result = {4'b0, cap_a / cap_b};
        end
      end
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= IDW'(NREQ - 1);
      cap_id      <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_op      <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
      op_count    <= '0;
      err_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            cap_id <= gnt_id;
            cap_a  <= gnt_a;
            cap_b  <= gnt_b;
            cap_op <= gnt_op;
            ptr    <= gnt_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_error  <= alu_error;
          resp_id     <= cap_id;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (op_count != '1) op_count <= op_count + 1'b1;
            if (resp_error && (err_count != '1)) err_count <= err_count + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: a vector table of single operations, then fairness, stall and reset sequences.
module tb_calc_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 3;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [2*NREQ-1:0] req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [7:0]        resp_result;
  logic              resp_error;
  logic [CNTW-1:0]   op_count;
  logic [CNTW-1:0]   err_count;
  logic              busy;

  calc_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_error(resp_error),
    .op_count(op_count), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [3:0]     a;
    logic [3:0]     b;
    logic [1:0]     op;
    logic [7:0]     result;
    logic           err;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ops  = 0;
  int   exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; leaves the bench at a negedge with the DUT idle again.
  task automatic do_op(input vec_t v);
    req_a  = 8'hFF;
    req_b  = 8'hFF;
    req_op = 4'hF;
    req_a[4*v.id +: 4]  = v.a;
    req_b[4*v.id +: 4]  = v.b;
    req_op[2*v.id +: 2] = v.op;
    req_valid = NREQ'(1) << v.id;
    #1;
    chk("grant_ready", 32'(req_ready), 32'(NREQ'(1) << v.id));
    chk("idle_resp_valid", 32'(resp_valid), 0);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    #1;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_ready", 32'(req_ready), 0);
    chk("exec_resp_valid", 32'(resp_valid), 0);
    @(posedge clk); @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_id", 32'(resp_id), 32'(v.id));
    chk("resp_result", 32'(resp_result), 32'(v.result));
    chk("resp_error", 32'(resp_error), 32'(v.err));
    resp_ready = 1'b1;
    exp_ops++;
    if (v.err) exp_errs++;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("post_resp_valid", 32'(resp_valid), 0);
    chk("post_busy", 32'(busy), 0);
    chk("op_count", 32'(op_count), 32'(exp_ops));
    chk("err_count", 32'(err_count), 32'(exp_errs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int nresp;
    int last_c;

    vecs[0] = '{3'd0, 4'd3,  4'd4,  2'b00, 8'h07, 1'b0};
    vecs[1] = '{3'd1, 4'd9,  4'd0,  2'b11, 8'h00, 1'b1};
    vecs[2] = '{3'd0, 4'd2,  4'd5,  2'b01, 8'hFD, 1'b0};
    vecs[3] = '{3'd1, 4'd15, 4'd15, 2'b10, 8'hE1, 1'b0};
    vecs[4] = '{3'd0, 4'd13, 4'd4,  2'b11, 8'h03, 1'b0};
    vecs[5] = '{3'd1, 4'd15, 4'd15, 2'b00, 8'h1E, 1'b0};
    vecs[6] = '{3'd0, 4'd0,  4'd1,  2'b01, 8'hFF, 1'b0};
    vecs[7] = '{3'd1, 4'd14, 4'd3,  2'b11, 8'h04, 1'b0};
    vecs[8] = '{3'd0, 4'd0,  4'd0,  2'b11, 8'h00, 1'b1};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_result", 32'(resp_result), 0);
    chk("rst_resp_error", 32'(resp_error), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vecs[i]);

    // Fresh reset so the pointer starts at NREQ-1 and rotation begins at requester 0.
    rst_n = 1'b0;
    #1;
    chk("rst2_op_count", 32'(op_count), 0);
    chk("rst2_err_count", 32'(err_count), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_ops  = 0;
    exp_errs = 0;

    req_a      = {4'd2, 4'd1};
    req_b      = {4'd3, 4'd1};
    req_op     = {2'b10, 2'b00};
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    ngr    = 0;
    nresp  = 0;
    last_c = -3;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (req_ready != '0) begin
        chk("fair_order", 32'(req_ready), (ngr % 2 == 0) ? 32'd1 : 32'd2);
        chk("fair_spacing", 32'(c - last_c), 3);
        last_c = c;
        ngr++;
      end
      if (resp_valid) begin
        chk("fair_resp_id", 32'(resp_id), 32'(nresp % 2));
        chk("fair_result", 32'(resp_result), (nresp % 2 == 0) ? 32'd2 : 32'd6);
        nresp++;
      end
      @(negedge clk);
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    #1;
    chk("fair_grants", 32'(ngr), 6);
    chk("fair_resps", 32'(nresp), 6);
    chk("fair_op_count", 32'(op_count), 6);

    // Stall in RESP with requester 1 waiting.
    @(negedge clk);
    req_a     = {4'd7, 4'd5};
    req_b     = {4'd7, 4'd6};
    req_op    = {2'b00, 2'b10};
    req_valid = 2'b11;
    #1;
    chk("stall_grant", 32'(req_ready), 1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", 32'(resp_valid), 1);
      chk("stall_id", 32'(resp_id), 0);
      chk("stall_result", 32'(resp_result), 30);
      chk("stall_error", 32'(resp_error), 0);
      chk("stall_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 2'b10;
    #1;
    chk("waiting_grant", 32'(req_ready), 2);
    chk("stall_op_count", 32'(op_count), 7);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("waiting_resp_id", 32'(resp_id), 1);
    chk("waiting_result", 32'(resp_result), 14);
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("waiting_op_count", 32'(op_count), 8);

    // Reset during EXEC.
    @(negedge clk);
    req_a     = {4'd0, 4'd4};
    req_b     = {4'd0, 4'd2};
    req_op    = {2'b00, 2'b11};
    req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_resp_valid", 32'(resp_valid), 0);
    chk("rstx_op_count", 32'(op_count), 0);
    chk("rstx_err_count", 32'(err_count), 0);
    chk("rstx_resp_id", 32'(resp_id), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rstx_next_grant", 32'(req_ready), 1);

    // Reset during RESP must drop resp_valid at once.
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    chk("rstr_pre_valid", 32'(resp_valid), 1);
    chk("rstr_pre_result", 32'(resp_result), 2);
    rst_n = 1'b0;
    #1;
    chk("rstr_valid", 32'(resp_valid), 0);
    chk("rstr_result", 32'(resp_result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
